// File: rtl/da_tx_if.sv
// Stream and fx-bus signal bundle for the serial DAC transmitter.
// The transmitter is the slave on both the stream and the fx bus.
interface da_tx_if;
   logic [15:0] da_data;
   logic        da_vld;
   logic        da_rdy;
   logic [21:0] fx_waddr;
   logic        fx_wr;
   logic [7:0]  fx_data;
   logic        fx_rd;
   logic [21:0] fx_raddr;
   logic [7:0]  fx_q;

   modport master (
      output da_data, da_vld, fx_waddr, fx_wr, fx_data, fx_rd, fx_raddr,
      input  da_rdy, fx_q
   );

   modport slave (
      input  da_data, da_vld, fx_waddr, fx_wr, fx_data, fx_rd, fx_raddr,
      output da_rdy, fx_q
   );
endinterface

// File: rtl/da_tx.sv
// Serial DAC transmitter: shifts 16-bit words MSB-first on cs_n/sclk/sdin,
// sourced from a valid/ready stream or from fx-bus data registers.
//
// state | meaning
// IDLE  | outputs idle, waiting for a stream word or a GO write
// SETUP | cs_n low, sclk high for H cycles before the first falling edge
// SHIFT | 16 bits, each sclk low H cycles then high H cycles
// HOLD  | cs_n low, sclk high for H cycles after bit 0
// GAP   | cs_n high for 2H cycles before the next frame may start
module da_tx #(
   parameter logic [7:0] DIV_DEFAULT = 8'd4,
   parameter int         FRAME_BITS  = 16
) (
   input  logic       clk_sys,
   input  logic       rst_n,
   input  logic [5:0] dev_id,
   da_tx_if.slave     bus,
   output logic       cs_n,
   output logic       sclk,
   output logic       sdin
);

   localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      SHIFT = 3'd2,
      HOLD  = 3'd3,
      GAP   = 3'd4
   } state_t;

   state_t      state;
   logic [8:0]  tmr;
   logic [7:0]  h_lat;
   logic [14:0] shreg;
   logic [3:0]  bit_idx;

   logic [7:0]  dlo, dhi, div, cnt, rdata, q_r;
   logic        src, rdy_en;
   logic        wr_sel, rd_sel, busy, go, start, frame_done;
   logic [15:0] woff, roff, start_word;

   assign wr_sel     = bus.fx_wr && (bus.fx_waddr[21:16] == dev_id);
   assign rd_sel     = bus.fx_rd && (bus.fx_raddr[21:16] == dev_id);
   assign woff       = bus.fx_waddr[15:0];
   assign roff       = bus.fx_raddr[15:0];
   assign busy       = (state != IDLE);
   assign bus.da_rdy = rdy_en && !busy && !src;
   assign go         = wr_sel && (woff == 16'h0002) && bus.fx_data[1] && src && !busy;
   assign start      = go || (bus.da_vld && bus.da_rdy);
   assign start_word = src ? {dhi, dlo} : bus.da_data;
   assign frame_done = (state == HOLD) && (tmr == 9'd0);
   assign bus.fx_q   = q_r;

   always_comb begin
      rdata = 8'h00;
      case (roff)
         16'h0000: rdata = dlo;
         16'h0001: rdata = dhi;
         16'h0002: rdata = {7'b0, src};
         16'h0003: rdata = div;
         16'h0004: rdata = {6'b0, src, busy};
         16'h0005: rdata = cnt;
         default:  rdata = 8'h00;
      endcase
   end

   // rdy_en keeps da_rdy low while reset is asserted and until the first clock.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         dlo    <= 8'h00;
         dhi    <= 8'h00;
         div    <= DIV_DEFAULT;
         src    <= 1'b0;
         cnt    <= 8'h00;
         q_r    <= 8'h00;
         rdy_en <= 1'b0;
      end else begin
         rdy_en <= 1'b1;
         if (wr_sel) begin
            case (woff)
               16'h0000: dlo <= bus.fx_data;
               16'h0001: dhi <= bus.fx_data;
               16'h0002: src <= bus.fx_data[0];
               16'h0003: div <= bus.fx_data;
               default:  ;
            endcase
         end
         if (wr_sel && (woff == 16'h0005))
            cnt <= 8'h00;
         else if (frame_done)
            cnt <= cnt + 8'd1;
         q_r <= rd_sel ? rdata : 8'h00;
      end
   end

   // Every phase timer loads H-1 (or 2H-1) and leaves its phase when it reaches 0.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         tmr     <= 9'd0;
         h_lat   <= 8'h00;
         shreg   <= 15'h0000;
         bit_idx <= 4'd0;
         cs_n    <= 1'b1;
         sclk    <= 1'b1;
         sdin    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state   <= SETUP;
                  h_lat   <= div;
                  tmr     <= {1'b0, div};
                  shreg   <= start_word[14:0];
                  bit_idx <= LAST_BIT;
                  cs_n    <= 1'b0;
                  sdin    <= start_word[15];
               end
            end
            SETUP: begin
               if (tmr == 9'd0) begin
                  state <= SHIFT;
                  sclk  <= 1'b0;
                  tmr   <= {1'b0, h_lat};
               end else begin
                  tmr <= tmr - 9'd1;
               end
            end
            SHIFT: begin
               if (tmr != 9'd0) begin
                  tmr <= tmr - 9'd1;
               end else if (!sclk) begin
                  sclk <= 1'b1;
                  tmr  <= {1'b0, h_lat};
               end else if (bit_idx == 4'd0) begin
                  state <= HOLD;
                  tmr   <= {1'b0, h_lat};
               end else begin
                  sclk    <= 1'b0;
                  bit_idx <= bit_idx - 4'd1;
                  sdin    <= shreg[14];
                  shreg   <= {shreg[13:0], 1'b0};
                  tmr     <= {1'b0, h_lat};
               end
            end
            HOLD: begin
               if (tmr == 9'd0) begin
                  state <= GAP;
                  cs_n  <= 1'b1;
                  sdin  <= 1'b0;
                  tmr   <= {h_lat, 1'b1};
               end else begin
                  tmr <= tmr - 9'd1;
               end
            end
            GAP: begin
               if (tmr == 9'd0)
                  state <= IDLE;
               else
                  tmr <= tmr - 9'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
